// File: rtl/duck_bus_target.sv
// Responder for the 8-bit multiplexed external bus: two-byte address phase, then
// a write byte or a turnaround plus read byte, with a registered one-cycle acknowledge.
module duck_bus_target #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic        wr,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        ack,
    output logic        err,
    input  logic [7:0]  status_in,
    output logic [55:0] regs_q,
    output logic [6:0]  wr_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        WDATA,
        TURN,
        RDATA
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] addr;
    logic [15:0] addr_nx;
    logic        wr_q;
    logic        wr_nx;
    logic [7:0]  regs    [0:6];
    logic [7:0]  regs_nx [0:6];
    logic [7:0]  bus_out_nx;
    logic [7:0]  bus_oe_nx;
    logic        ack_nx;
    logic        err_nx;
    logic [6:0]  wr_pulse_nx;

    logic        hit;
    logic [2:0]  offset;
    logic [7:0]  rdata;

    assign hit    = (addr[15:3] == BASE_ADDR[15:3]);
    assign offset = addr[2:0];

    always_comb begin
        rdata = 8'hFF;
        if (hit) begin
            if (offset == 3'd7) begin
                rdata = status_in;
            end else begin
                for (int unsigned i = 0; i < 7; i++) begin
                    if (offset == 3'(i)) begin
                        rdata = regs[i];
                    end
                end
            end
        end
    end

    always_comb begin
        regs_q = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            regs_q[8*i +: 8] = regs[i];
        end
    end

    // Outputs for the next cycle are decided here and registered below, so the
    // ack/data cycle (RDATA or first IDLE after WDATA) sees only flop outputs.
    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        wr_nx       = wr_q;
        regs_nx     = regs;
        bus_out_nx  = '0;
        bus_oe_nx   = '0;
        ack_nx      = 1'b0;
        err_nx      = 1'b0;
        wr_pulse_nx = '0;

        case (state)
            IDLE: begin
                if (strobe) begin
                    addr_nx[15:8] = bus_in;
                    wr_nx         = wr;
                    state_nx      = ADDR_LO;
                end
            end
            ADDR_LO: begin
                addr_nx[7:0] = bus_in;
                state_nx     = wr_q ? WDATA : TURN;
            end
            WDATA: begin
                ack_nx   = 1'b1;
                err_nx   = !hit;
                state_nx = IDLE;
                if (hit && offset != 3'd7) begin
                    for (int unsigned i = 0; i < 7; i++) begin
                        if (offset == 3'(i)) begin
                            regs_nx[i]     = bus_in;
                            wr_pulse_nx[i] = 1'b1;
                        end
                    end
                end
            end
            TURN: begin
                ack_nx     = 1'b1;
                err_nx     = !hit;
                bus_oe_nx  = '1;
                bus_out_nx = rdata;
                state_nx   = RDATA;
            end
            RDATA: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            wr_q     <= 1'b0;
            regs     <= '{default: '0};
            bus_out  <= '0;
            bus_oe   <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            wr_pulse <= '0;
        end else begin
            state    <= state_nx;
            addr     <= addr_nx;
            wr_q     <= wr_nx;
            regs     <= regs_nx;
            bus_out  <= bus_out_nx;
            bus_oe   <= bus_oe_nx;
            ack      <= ack_nx;
            err      <= err_nx;
            wr_pulse <= wr_pulse_nx;
        end
    end

endmodule

// File: tb/tb_duck_bus_target.sv
// Bench for duck_bus_target: transaction-level model checked every cycle, plus
// hand-computed expectations pinned at specific cycles.
module tb_duck_bus_target;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  bus_in = '0;
    logic [7:0]  status_in = '0;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic        ack;
    logic        err;
    logic [55:0] regs_q;
    logic [6:0]  wr_pulse;

    duck_bus_target #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .strobe    (strobe),
        .wr        (wr),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .ack       (ack),
        .err       (err),
        .status_in (status_in),
        .regs_q    (regs_q),
        .wr_pulse  (wr_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-owned transaction announcements and pinned expectations
    int          tx_seq = 0;
    logic [15:0] tx_addr = '0;
    logic        tx_wr = 1'b0;
    logic [7:0]  tx_data = '0;

    int          pin_wr = 0;
    int          pin_at  [0:63];
    int          pin_sel [0:63];
    logic [55:0] pin_exp [0:63];
    string       pin_nm  [0:63];

    // Model-owned state (compare process only)
    int          tests = 0;
    int          fails = 0;
    int          seen_seq = 0;
    int          pin_rd = 0;
    logic [7:0]  mreg    [0:6];
    logic        m_ack   [0:63];
    logic        m_err   [0:63];
    logic [6:0]  m_wp    [0:63];
    logic        m_wen   [0:63];
    int          m_woff  [0:63];
    logic [7:0]  m_wdat  [0:63];
    logic        m_rd    [0:63];
    logic [15:0] m_raddr [0:63];
    logic        m_samp  [0:63];
    logic [7:0]  m_stat  [0:63];

    task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int          s;
        int          s3;
        int          off;
        logic [7:0]  e_out;
        logic [7:0]  e_oe;
        logic [55:0] e_regs;
        logic [55:0] act;

        s = cyc % 64;
        if (rst) begin
            for (int i = 0; i < 7; i++) mreg[i] = '0;
            for (int i = 0; i < 64; i++) begin
                m_ack[i] = 0; m_err[i] = 0; m_wp[i] = '0; m_wen[i] = 0;
                m_rd[i] = 0; m_samp[i] = 0;
            end
            seen_seq = tx_seq;
        end else if (tx_seq != seen_seq) begin
            seen_seq = tx_seq;
            s3  = (cyc + 3) % 64;
            off = int'(tx_addr % 16'd8);
            m_ack[s3] = 1'b1;
            m_err[s3] = ((tx_addr & 16'hFFF8) != BASE);
            if (tx_wr) begin
                if (!m_err[s3] && off < 7) begin
                    m_wen[s3]  = 1'b1;
                    m_woff[s3] = off;
                    m_wdat[s3] = tx_data;
                    m_wp[s3]   = 7'd1 << off;
                end
            end else begin
                m_samp[(cyc + 2) % 64] = 1'b1;
                m_rd[s3]    = 1'b1;
                m_raddr[s3] = tx_addr;
            end
        end

        if (m_wen[s]) mreg[m_woff[s]] = m_wdat[s];
        if (m_samp[s]) m_stat[(s + 1) % 64] = status_in;

        e_out = '0;
        e_oe  = '0;
        if (m_rd[s]) begin
            e_oe = 8'hFF;
            off  = int'(m_raddr[s] % 16'd8);
            if ((m_raddr[s] & 16'hFFF8) != BASE) e_out = 8'hFF;
            else if (off == 7)                    e_out = m_stat[s];
            else                                  e_out = mreg[off];
        end
        e_regs = '0;
        for (int i = 0; i < 7; i++) e_regs[8*i +: 8] = mreg[i];

        chk("model_ack",      56'(ack),      56'(m_ack[s]));
        chk("model_err",      56'(err),      56'(m_err[s]));
        chk("model_wr_pulse", 56'(wr_pulse), 56'(m_wp[s]));
        chk("model_bus_oe",   56'(bus_oe),   56'(e_oe));
        chk("model_bus_out",  56'(bus_out),  56'(e_out));
        chk("model_regs_q",   regs_q,        e_regs);

        m_ack[s] = 0; m_err[s] = 0; m_wp[s] = '0; m_wen[s] = 0;
        m_rd[s] = 0; m_samp[s] = 0;

        while (pin_rd < pin_wr && pin_at[pin_rd] <= cyc) begin
            case (pin_sel[pin_rd])
                0:       act = 56'(ack);
                1:       act = 56'(err);
                2:       act = 56'(wr_pulse);
                3:       act = 56'(bus_oe);
                4:       act = 56'(bus_out);
                default: act = regs_q;
            endcase
            if (pin_at[pin_rd] < cyc) chk({pin_nm[pin_rd], "_missed"}, 56'(cyc), 56'(pin_at[pin_rd]));
            else                      chk(pin_nm[pin_rd], act, pin_exp[pin_rd]);
            pin_rd++;
        end
    end

    localparam int ACK = 0, ERR = 1, WP = 2, OE = 3, OUT = 4, REGS = 5;

    task automatic pin(input string nm, input int at, input int sel, input logic [55:0] e);
        pin_nm[pin_wr]  = nm;
        pin_at[pin_wr]  = at;
        pin_sel[pin_wr] = sel;
        pin_exp[pin_wr] = e;
        pin_wr++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic announce(input logic [15:0] a, input logic w, input logic [7:0] d);
        tx_addr = a;
        tx_wr   = w;
        tx_data = d;
        tx_seq++;
    endtask

    task automatic write_tx(input logic [15:0] a, input logic [7:0] d, output int k);
        step();
        k = cyc;
        strobe = 1'b1; wr = 1'b1; bus_in = a[15:8];
        announce(a, 1'b1, d);
        step();
        strobe = 1'b0; wr = 1'b0; bus_in = a[7:0];
        step();
        bus_in = d;
    endtask

    task automatic read_tx(input logic [15:0] a, input logic viol, output int k);
        step();
        k = cyc;
        strobe = 1'b1; wr = 1'b0; bus_in = a[15:8];
        announce(a, 1'b0, 8'h00);
        step();
        strobe = viol; wr = viol; bus_in = a[7:0];
        step();
        strobe = viol; wr = viol; bus_in = 8'hFF;
        step();
        strobe = 1'b0; wr = 1'b0; bus_in = '0;
    endtask

    initial begin
        int k;

        pin("reset_regs", 1, REGS, '0);
        pin("reset_oe",   1, OE,   '0);
        repeat (3) step();
        rst = 1'b0;

        write_tx(16'hFF03, 8'hA5, k);
        pin("wr03_ack",  k + 3, ACK,  56'd1);
        pin("wr03_wp",   k + 3, WP,   56'(7'b0001000));
        pin("wr03_regs", k + 3, REGS, 56'h000000A5000000);
        pin("wr03_ack_off", k + 4, ACK, 56'd0);

        read_tx(16'hFF03, 1'b0, k);
        pin("rd03_oe",  k + 3, OE,  56'hFF);
        pin("rd03_out", k + 3, OUT, 56'hA5);
        pin("rd03_ack", k + 3, ACK, 56'd1);
        pin("rd03_err", k + 3, ERR, 56'd0);
        pin("rd03_release", k + 4, OE, 56'd0);

        status_in = 8'h3C;
        read_tx(16'hFF07, 1'b0, k);
        pin("rd07_out", k + 3, OUT, 56'h3C);
        pin("rd07_err", k + 3, ERR, 56'd0);

        write_tx(16'hFF07, 8'h11, k);
        pin("wr07_ack",  k + 3, ACK,  56'd1);
        pin("wr07_err",  k + 3, ERR,  56'd0);
        pin("wr07_wp",   k + 3, WP,   56'd0);
        pin("wr07_regs", k + 3, REGS, 56'h000000A5000000);

        read_tx(16'hFE03, 1'b0, k);
        pin("rdmiss_out", k + 3, OUT, 56'hFF);
        pin("rdmiss_ack", k + 3, ACK, 56'd1);
        pin("rdmiss_err", k + 3, ERR, 56'd1);

        write_tx(16'h0003, 8'h77, k);
        pin("wrmiss_ack",  k + 3, ACK,  56'd1);
        pin("wrmiss_err",  k + 3, ERR,  56'd1);
        pin("wrmiss_wp",   k + 3, WP,   56'd0);
        pin("wrmiss_regs", k + 3, REGS, 56'h000000A5000000);

        write_tx(16'hFF00, 8'h01, k);
        pin("b2b_ack1", k + 3, ACK, 56'd1);
        pin("b2b_wp1",  k + 3, WP,  56'(7'b0000001));
        pin("b2b_gap",  k + 4, ACK, 56'd0);
        pin("b2b_ack2", k + 6, ACK, 56'd1);
        pin("b2b_wp2",  k + 6, WP,  56'(7'b1000000));
        pin("b2b_regs", k + 6, REGS, 56'h020000A5000001);
        write_tx(16'hFF06, 8'h02, k);

        write_tx(16'hFF01, 8'h5A, k);
        read_tx(16'hFF01, 1'b1, k);
        pin("viol_out",  k + 3, OUT,  56'h5A);
        pin("viol_ack",  k + 3, ACK,  56'd1);
        pin("viol_idle", k + 4, OE,   56'd0);
        pin("viol_regs", k + 4, REGS, 56'h020000A5005A01);
        repeat (3) step();

        // Abort a write in its data cycle with an asynchronous reset
        step();
        k = cyc;
        strobe = 1'b1; wr = 1'b1; bus_in = 8'hFF;
        announce(16'hFF02, 1'b1, 8'h99);
        step();
        strobe = 1'b0; wr = 1'b0; bus_in = 8'h02;
        step();
        bus_in = 8'h99;
        #2 rst = 1'b1;
        pin("abort_regs", k + 2, REGS, '0);
        pin("abort_ack",  k + 2, ACK,  56'd0);
        pin("abort_no_ack",  k + 3, ACK,  56'd0);
        pin("abort_no_wp",   k + 3, WP,   56'd0);
        pin("abort_regs_after", k + 3, REGS, '0);
        step();
        rst = 1'b0;

        write_tx(16'hFF05, 8'hC3, k);
        pin("wr05_wp",   k + 3, WP,   56'(7'b0100000));
        pin("wr05_regs", k + 3, REGS, 56'h00C30000000000);
        read_tx(16'hFF05, 1'b0, k);
        pin("rd05_out", k + 3, OUT, 56'hC3);

        status_in = 8'h81;
        read_tx(16'hFF07, 1'b0, k);
        pin("rd07b_out", k + 3, OUT, 56'h81);

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
